// File: rtl/lut_sweep_unit.sv
// Run-time reloadable N_IN-input truth table. Vectors are evaluated either from a
// valid/ready input stream or by an internal exhaustive sweep, through one registered output stage.
module lut_sweep_unit #(
  parameter int unsigned              N_IN       = 3,
  parameter logic [(1<<N_IN)-1:0]     DEFAULT_TT = 8'h31
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cfg_load,
  input  logic            i_cfg_bit,
  input  logic            i_cfg_bit_valid,
  input  logic            i_sweep_start,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [N_IN-1:0] i_in_vec,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [N_IN-1:0] o_out_vec,
  output logic            o_out_y,
  output logic            o_out_last,
  output logic            o_busy,
  output logic            o_done,
  output logic [N_IN:0]   o_ones_count
);

  localparam int unsigned   N_ENT    = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(N_ENT - 1);
  localparam logic [N_IN:0] ONE      = {{N_IN{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_SWEEP     = 2'd2;
  localparam logic [1:0] S_WAIT_LAST = 2'd3;

  logic [1:0]       r_state;
  logic [N_ENT-1:0] r_tt;
  logic [N_ENT-1:0] r_shadow;
  logic [N_IN:0]    r_cnt;
  logic [N_IN:0]    r_v;
  logic             r_out_valid;
  logic [N_IN-1:0]  r_out_vec;
  logic             r_out_y;
  logic             r_out_last;
  logic             r_done;
  logic [N_IN:0]    r_ones;

  logic             w_idle;
  logic             w_out_free;
  logic             w_in_ready;
  logic             w_sweep_y;
  logic [N_ENT-1:0] w_shadow_next;

  assign w_idle     = (r_state == S_IDLE);
  assign w_out_free = ~r_out_valid | i_out_ready;
  assign w_in_ready = w_idle & ~i_cfg_load & ~i_sweep_start & w_out_free;
  assign w_sweep_y  = r_tt[r_v[N_IN-1:0]];

  // Shadow image including the bit arriving this cycle, so the final bit commits atomically.
  always_comb begin
    w_shadow_next                    = r_shadow;
    w_shadow_next[r_cnt[N_IN-1:0]]   = i_cfg_bit;
  end

  // Control FSM, table storage and registered output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_tt        <= DEFAULT_TT;
      r_shadow    <= {N_ENT{1'b0}};
      r_cnt       <= {(N_IN+1){1'b0}};
      r_v         <= {(N_IN+1){1'b0}};
      r_out_valid <= 1'b0;
      r_out_vec   <= {N_IN{1'b0}};
      r_out_y     <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_ones      <= {(N_IN+1){1'b0}};
    end else begin
      r_done <= 1'b0;
      if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_cfg_load) begin
            r_state  <= S_LOAD;
            r_cnt    <= {(N_IN+1){1'b0}};
            r_shadow <= {N_ENT{1'b0}};
          end else if (i_sweep_start) begin
            r_state <= S_SWEEP;
            r_v     <= {(N_IN+1){1'b0}};
            r_ones  <= {(N_IN+1){1'b0}};
          end else if (i_in_valid && w_in_ready) begin
            r_out_valid <= 1'b1;
            r_out_vec   <= i_in_vec;
            r_out_y     <= r_tt[i_in_vec];
            r_out_last  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_cfg_load) begin
            r_cnt    <= {(N_IN+1){1'b0}};
            r_shadow <= {N_ENT{1'b0}};
          end else if (i_cfg_bit_valid) begin
            r_shadow <= w_shadow_next;
            r_cnt    <= r_cnt + ONE;
            if (r_cnt == LAST_IDX) begin
              r_tt    <= w_shadow_next;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_SWEEP: begin
          if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_vec   <= r_v[N_IN-1:0];
            r_out_y     <= w_sweep_y;
            r_out_last  <= (r_v == LAST_IDX);
            r_ones      <= r_ones + {{N_IN{1'b0}}, w_sweep_y};
            r_v         <= r_v + ONE;
            if (r_v == LAST_IDX) begin
              r_state <= S_WAIT_LAST;
            end
          end
        end
        S_WAIT_LAST: begin
          // Only the out_last beat can be pending here.
          if (r_out_valid && i_out_ready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_vec    = r_out_vec;
  assign o_out_y      = r_out_y;
  assign o_out_last   = r_out_last;
  assign o_busy       = ~w_idle;
  assign o_done       = r_done;
  assign o_ones_count = r_ones;

endmodule

// File: doc/lut_sweep_unit.md
Name: lut_sweep_unit

Overview:
Parametrised, registered successor to the fixed 3-input boolean function block. It holds an N_IN-input truth table that can be reloaded at run time, and evaluates it two ways: vectors streamed in through a valid/ready port, or an internal exhaustive sweep of all 2^N_IN input vectors. The sweep replaces hand-written stimulus sequences, and each result leaves through a registered valid/ready output stage.

Parameters:
N_IN, 3, number of function inputs; legal range 1..8.
DEFAULT_TT, 8'h31, reset truth table of width 2^N_IN; bit i = output for input vector i. 8'h31 = ~b&~c | a&~b with {a,b,c} = vector[2:0].

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_load  in  1  pulse; start serial table load
cfg_bit  in  1  serial table bit
cfg_bit_valid  in  1  qualifies cfg_bit
sweep_start  in  1  pulse; start exhaustive sweep
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted when in_valid&in_ready
in_vec  in  N_IN  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vec  out  N_IN  vector that produced out_y
out_y  out  1  tt[out_vec]
out_last  out  1  marks final sweep beat
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: load committed or sweep finished
ones_count  out  N_IN+1  number of 1 results in the last sweep

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, tt=DEFAULT_TT, out_valid/out_y/out_last/done=0, out_vec=0, ones_count=0. Any partial load or sweep in progress is discarded.
- States: IDLE, LOAD, SWEEP, WAIT_LAST. busy = (state != IDLE).
- Output stage is free when !out_valid | out_ready.
- Output stage rule: out_valid stays high, and out_vec/out_y/out_last stay stable, until out_ready is sampled high.
- IDLE command priority:
  - cfg_load wins over sweep_start.
  - sweep_start wins over an input handshake.
  - cfg_load and sweep_start are ignored in any other state, except that cfg_load in LOAD restarts the load.
- IDLE input handshake: in_ready = IDLE & !cfg_load & !sweep_start & output stage free. On a handshake, the next cycle has out_valid=1, out_vec=in_vec, out_y=tt[in_vec], out_last=0 (latency 1). Back-to-back handshakes give 1 result per cycle.
- LOAD:
  - A 2^N_IN-bit shadow register and a bit counter start at 0.
  - Each cycle with cfg_bit_valid writes cfg_bit to shadow[cnt] and increments cnt, entry 0 first.
  - On the final bit, tt is replaced atomically with the full shadow on the next edge, done=1 for that cycle, and state returns to IDLE.
  - cfg_load in LOAD resets cnt to 0.
  - tt never holds a partially loaded table.
  - A pending output beat continues to drain during LOAD.
- SWEEP:
  - On entry, vector counter v=0 and ones_count=0.
  - Each cycle the output stage is free, the block issues out_vec=v, out_y=tt[v], out_last=(v==2^N_IN-1), adds out_y to ones_count, and increments v.
  - After the last beat is issued, state goes to WAIT_LAST.
- WAIT_LAST: when the out_last beat is accepted, done=1 next cycle, state returns to IDLE, and ones_count holds until the next sweep.
- Width rules: v and cnt are N_IN+1 bits, so no wrap ambiguity. ones_count is N_IN+1 bits, and its maximum value 2^N_IN fits.
- Simultaneous events: a cfg_bit_valid in the cycle the final bit commits is ignored. done never coincides with out_valid rising from an IDLE handshake in the same cycle.

Test Plan:
1. Reset, then stream in_vec 0..7 with out_ready=1 -> out_y = 1,0,0,0,1,1,0,0, each one cycle after its handshake; in_ready=1 throughout.
2. sweep_start with out_ready=1 -> 8 consecutive beats, out_vec 0..7, out_last only on 7, done 1 cycle after the last accept, ones_count=3, busy low after done.
3. Sweep with out_ready alternating 1/0 -> outputs stable while stalled, each vector exactly once, in order, ones_count=3.
4. Load 8'h96 LSB first with random cfg_bit_valid gaps; check evals of vec 7 before the load (y=0) and after the commit (y=1) -> done pulse at commit; a following sweep gives parity results and ones_count=4.
5. Send 5 bits, reassert cfg_load, then load 8'hFF -> tt=8'hFF and sweep ones_count=8. Then rst_n=0 mid-sweep at vec 3 -> next cycle out_valid=0, busy=0, tt=8'h31.
6. N_IN=4, DEFAULT_TT=16'h8000, sweep -> 16 beats, only vec 15 gives y=1, ones_count=5'd1.
